// File: rtl/packed_pair_mac.sv
// packed_pair_mac: 3-stage pairwise multiply, adder tree and N_ACC-frame accumulator over a packed signed-word frame.
// Define PACKED_PAIR_MAC_SAT_EN to saturate o_data and flag o_overflow instead of wrapping to NB_OUT bits.
module packed_pair_mac #(
    parameter int NB_DATA = 8,
    parameter int N_WORD  = 8,
    parameter int N_ACC   = 4,
    parameter int NB_OUT  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NB_DATA*N_WORD-1:0]   i_data,
    input  logic                        i_valid,
    input  logic                        i_clear,
    output logic signed [NB_OUT-1:0]    o_data,
    output logic                        o_valid,
    output logic                        o_overflow
);
    localparam int NB_PROD = 2 * NB_DATA;
    localparam int N_PAIR  = N_WORD / 2;
    localparam int NB_SUM  = NB_PROD + $clog2(N_PAIR);
    localparam int NB_ACC  = NB_SUM + $clog2(N_ACC);
    localparam int NB_CNT  = $clog2(N_ACC + 1);

    logic signed [NB_PROD-1:0] r_prod [N_PAIR];
    logic signed [NB_SUM-1:0]  r_sum, w_sum;
    logic signed [NB_ACC-1:0]  r_acc, w_tot;
    logic signed [NB_OUT-1:0]  w_fmt;
    logic [NB_CNT-1:0]         r_cnt;
    logic                      r_v1, r_v2, w_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v1 <= 1'b0;
            for (int k = 0; k < N_PAIR; k++) r_prod[k] <= '0;
        end else begin
            r_v1 <= i_valid;
            if (i_valid)
                for (int k = 0; k < N_PAIR; k++)
                    r_prod[k] <= signed'(i_data[(2*k+1)*NB_DATA-1 -: NB_DATA]) *
                                 signed'(i_data[(2*k+2)*NB_DATA-1 -: NB_DATA]);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < N_PAIR; k++) w_sum = w_sum + NB_SUM'(r_prod[k]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v2  <= 1'b0;
            r_sum <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) r_sum <= w_sum;
        end
    end

    // A clear coincident with v2 makes s the first frame of the new group.
    assign w_tot  = (i_clear ? '0 : r_acc) + NB_ACC'(r_sum);
    assign w_last = i_clear ? (N_ACC == 1) : (r_cnt == NB_CNT'(N_ACC - 1));

`ifdef PACKED_PAIR_MAC_SAT_EN
    localparam logic signed [NB_OUT-1:0] SAT_MAX = {1'b0, {(NB_OUT-1){1'b1}}};
    localparam logic signed [NB_OUT-1:0] SAT_MIN = {1'b1, {(NB_OUT-1){1'b0}}};
    logic signed [NB_ACC-1:0] w_hi;
    logic                     w_ovf, r_ovf;
    assign w_hi  = w_tot >>> (NB_OUT - 1);
    assign w_ovf = (NB_OUT < NB_ACC) && (w_hi != '0) && (w_hi != '1);
    assign w_fmt = w_ovf ? (w_tot[NB_ACC-1] ? SAT_MIN : SAT_MAX) : NB_OUT'(w_tot);
    assign o_overflow = r_ovf;
`else
    assign w_fmt = NB_OUT'(w_tot);
    assign o_overflow = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
`ifdef PACKED_PAIR_MAC_SAT_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            o_valid <= 1'b0;
            if (r_v2 && w_last) begin
                o_data  <= w_fmt;
                o_valid <= 1'b1;
                r_acc   <= '0;
                r_cnt   <= '0;
`ifdef PACKED_PAIR_MAC_SAT_EN
                r_ovf   <= w_ovf;
`endif
            end else if (r_v2) begin
                r_acc <= w_tot;
                r_cnt <= (i_clear ? '0 : r_cnt) + 1'b1;
            end else if (i_clear) begin
                r_acc <= '0;
                r_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_packed_pair_mac.sv
// tb_packed_pair_mac: directed tests for packed_pair_mac (defaults) plus an N_WORD=4, N_ACC=1 instance.
module tb_packed_pair_mac;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] i_data = '0;
    logic        i_valid = 1'b0, i_clear = 1'b0;
    logic [15:0] o_data;
    logic        o_valid, o_overflow;
    logic [31:0] d1 = '0;
    logic        v1 = 1'b0;
    logic [15:0] od1;
    logic        ov1, of1;

    int checks = 0, errors = 0;
    int n_pulse = 0;
    logic [15:0] last_data = '0;
    logic        last_ovf = 1'b0;

    always #5 clock = ~clock;

    packed_pair_mac u_dut (
        .clock(clock), .reset(reset), .i_data(i_data), .i_valid(i_valid), .i_clear(i_clear),
        .o_data(o_data), .o_valid(o_valid), .o_overflow(o_overflow)
    );

    packed_pair_mac #(.NB_DATA(8), .N_WORD(4), .N_ACC(1), .NB_OUT(16)) u_n1 (
        .clock(clock), .reset(reset), .i_data(d1), .i_valid(v1), .i_clear(1'b0),
        .o_data(od1), .o_valid(ov1), .o_overflow(of1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
        if (o_valid) begin
            n_pulse++;
            last_data = o_data;
            last_ovf  = o_overflow;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frames(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            i_data = {8{w}};
            i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run(2);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_data !== 16'h0) begin errors++; $display("FAIL reset_data got %h want 0000", o_data); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", o_overflow); end
        reset = 1'b0;
        run(1);
    endtask

    task automatic test_ones();
        n_pulse = 0;
        for (int i = 0; i < 4; i++) begin
            i_data = {8{8'd1}};
            i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        checks++; if (n_pulse != 0) begin errors++; $display("FAIL ones_early got %0d pulses want 0", n_pulse); end
        tick();
        checks++; if (n_pulse != 0) begin errors++; $display("FAIL ones_lat2 got %0d pulses want 0", n_pulse); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_data !== 16'd16) begin errors++; $display("FAIL ones_out got v=%b d=%h want v=1 d=0010", o_valid, o_data); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ones_pulse_len got %b want 0", o_valid); end
        checks++; if (o_data !== 16'd16) begin errors++; $display("FAIL ones_hold got %h want 0010", o_data); end
    endtask

    task automatic test_bubbles();
        n_pulse = 0;
        for (int i = 0; i < 4; i++) begin
            i_data = {48'h0, 8'd5, 8'hFC};
            i_valid = 1'b1;
            tick();
            i_valid = 1'b0;
            run(2);
        end
        run(3);
        checks++; if (n_pulse != 1) begin errors++; $display("FAIL bub_count got %0d want 1", n_pulse); end
        checks++; if (last_data !== 16'hFFB0) begin errors++; $display("FAIL bub_data got %h want ffb0", last_data); end
        checks++; if (last_ovf !== 1'b0) begin errors++; $display("FAIL bub_ovf got %b want 0", last_ovf); end
    endtask

    task automatic test_sat();
        logic [15:0] exp_d;
        logic        exp_o;
`ifdef PACKED_PAIR_MAC_SAT_EN
        exp_d = 16'h7FFF; exp_o = 1'b1;
`else
        exp_d = 16'h0000; exp_o = 1'b0;
`endif
        n_pulse = 0;
        last_data = 16'hAAAA;
        frames(8'h80, 4);
        run(4);
        checks++; if (n_pulse != 1) begin errors++; $display("FAIL sat_count got %0d want 1", n_pulse); end
        checks++; if (last_data !== exp_d) begin errors++; $display("FAIL sat_data got %h want %h", last_data, exp_d); end
        checks++; if (last_ovf !== exp_o) begin errors++; $display("FAIL sat_ovf got %b want %b", last_ovf, exp_o); end
    endtask

    task automatic test_reset_abort();
        n_pulse = 0;
        frames(8'd1, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        frames(8'd1, 4);
        run(4);
        checks++; if (n_pulse != 1) begin errors++; $display("FAIL abort_count got %0d want 1", n_pulse); end
        checks++; if (last_data !== 16'd16) begin errors++; $display("FAIL abort_data got %h want 0010", last_data); end
    endtask

    task automatic test_clear();
        n_pulse = 0;
        frames(8'd1, 3);
        frames(8'd1, 1);
        tick();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        checks++; if (n_pulse != 0) begin errors++; $display("FAIL clr_nopulse got %0d want 0", n_pulse); end
        frames(8'd1, 3);
        run(4);
        checks++; if (n_pulse != 1) begin errors++; $display("FAIL clr_count got %0d want 1", n_pulse); end
        checks++; if (last_data !== 16'd16) begin errors++; $display("FAIL clr_data got %h want 0010", last_data); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        d1 = {8'd6, 8'hFE, 8'd7, 8'd3};
        for (int i = 0; i < 6; i++) begin
            v1 = (i < 3);
            tick();
            exp_v = (i >= 2 && i <= 4);
            checks++; if (ov1 !== exp_v) begin errors++; $display("FAIL n1_valid[%0d] got %b want %b", i, ov1, exp_v); end
            if (exp_v) begin
                checks++; if (od1 !== 16'd9) begin errors++; $display("FAIL n1_data[%0d] got %h want 0009", i, od1); end
            end
        end
        checks++; if (of1 !== 1'b0) begin errors++; $display("FAIL n1_ovf got %b want 0", of1); end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_bubbles();
        test_sat();
        test_reset_abort();
        test_clear();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
